// File: rtl/me_pkg.sv
// Shared motion-estimation constants for the SAD producer and compare_22bit.
package me_pkg;

  localparam int PIX_W      = 8;
  localparam int SAD_W      = 22;
  localparam int N_CAND     = 16;
  localparam int BLK_PIXELS = 256;
  localparam int CNT_W      = 8;

  // True when a block of worst-case differences still fits in the accumulator.
  function automatic bit sad_fits(input int pix_w, input int sad_w, input int blk);
    longint max_sum;
    max_sum = longint'(blk) * ((longint'(1) << pix_w) - longint'(1));
    return max_sum < (longint'(1) << sad_w);
  endfunction

  // True when the pixel counter can reach the last pixel index.
  function automatic bit cnt_fits(input int cnt_w, input int blk);
    return longint'(blk - 1) < (longint'(1) << cnt_w);
  endfunction

endpackage

// File: rtl/sad_lane.sv
// One SAD candidate lane: absolute difference, running accumulator and the
// output register that holds the finished block SAD.
module sad_lane #(
  parameter int PIX_W = me_pkg::PIX_W,
  parameter int SAD_W = me_pkg::SAD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_clr,
  input  logic             acc_en,
  input  logic             load,
  input  logic [PIX_W-1:0] cur_pix,
  input  logic [PIX_W-1:0] ref_pix,
  output logic [SAD_W-1:0] sad
);

  logic [SAD_W-1:0] acc;
  logic [PIX_W-1:0] diff;
  logic [SAD_W-1:0] sum;

  // Absolute difference, zero-extended and added to the running total.
  always_comb begin
    diff = (cur_pix > ref_pix) ? (cur_pix - ref_pix) : (ref_pix - cur_pix);
    sum  = acc + SAD_W'(diff);
  end

  // Accumulator clears on abort or block end; the output register captures the final sum.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so acc and sad both update from pre-edge values.
    if (rst) begin
      acc <= '0;
      // NOTE: the output register is reset too, so the bus reads zero until a block completes.
      sad <= '0;
    end else begin
      if (acc_clr)
        acc <= '0;
      else if (acc_en)
        acc <= sum;
      if (load)
        sad <= sum;
    end
  end

endmodule

// File: rtl/sad_array16.sv
// 16-lane SAD producer: accumulates |cur - ref| per candidate over one block
// and presents the finished SADs on a held-stable valid/ready output.
module sad_array16 #(
  parameter int PIX_W      = me_pkg::PIX_W,
  parameter int SAD_W      = me_pkg::SAD_W,
  parameter int BLK_PIXELS = me_pkg::BLK_PIXELS,
  parameter int CNT_W      = me_pkg::CNT_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             blk_clr,
  input  logic                             pix_valid,
  output logic                             pix_ready,
  input  logic [PIX_W-1:0]                 cur_pix,
  input  logic [me_pkg::N_CAND*PIX_W-1:0]  ref_pix,
  output logic [CNT_W-1:0]                 pix_idx,
  output logic                             sad_valid,
  input  logic                             sad_ready,
  output logic [SAD_W-1:0]                 sad_out0,
  output logic [SAD_W-1:0]                 sad_out1,
  output logic [SAD_W-1:0]                 sad_out2,
  output logic [SAD_W-1:0]                 sad_out3,
  output logic [SAD_W-1:0]                 sad_out4,
  output logic [SAD_W-1:0]                 sad_out5,
  output logic [SAD_W-1:0]                 sad_out6,
  output logic [SAD_W-1:0]                 sad_out7,
  output logic [SAD_W-1:0]                 sad_out8,
  output logic [SAD_W-1:0]                 sad_out9,
  output logic [SAD_W-1:0]                 sad_out10,
  output logic [SAD_W-1:0]                 sad_out11,
  output logic [SAD_W-1:0]                 sad_out12,
  output logic [SAD_W-1:0]                 sad_out13,
  output logic [SAD_W-1:0]                 sad_out14,
  output logic [SAD_W-1:0]                 sad_out15
);

  import me_pkg::*;

  // Refuse to build a configuration that could overflow or cannot count a block.
  if (!sad_fits(PIX_W, SAD_W, BLK_PIXELS)) begin : g_sad_width_check
    $error("sad_array16: BLK_PIXELS*(2^PIX_W-1) does not fit in SAD_W bits");
  end
  if (!cnt_fits(CNT_W, BLK_PIXELS)) begin : g_cnt_width_check
    $error("sad_array16: CNT_W cannot hold BLK_PIXELS-1");
  end

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLK_PIXELS - 1);

  logic             is_last;
  logic             accept;
  logic             last_accept;
  logic             load;
  logic [SAD_W-1:0] sad [N_CAND];

  // Handshake decode: only the last pixel of a block waits for the consumer.
  always_comb begin
    is_last     = (pix_idx == LAST_IDX);
    pix_ready   = !(is_last && sad_valid && !sad_ready);
    accept      = pix_valid && pix_ready;
    last_accept = accept && is_last;
    load        = last_accept && !blk_clr;
  end

  // Pixel counter and result-valid flag; an abort on the last pixel suppresses the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_idx   <= '0;
      sad_valid <= 1'b0;
    end else begin
      if (blk_clr || last_accept)
        pix_idx <= '0;
      else if (accept)
        pix_idx <= pix_idx + CNT_W'(1);

      if (load)
        sad_valid <= 1'b1;
      else if (sad_ready)
        sad_valid <= 1'b0;
    end
  end

  for (genvar k = 0; k < N_CAND; k++) begin : g_lane
    sad_lane #(
      .PIX_W (PIX_W),
      .SAD_W (SAD_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .acc_clr (blk_clr || last_accept),
      .acc_en  (accept),
      .load    (load),
      .cur_pix (cur_pix),
      .ref_pix (ref_pix[k*PIX_W +: PIX_W]),
      .sad     (sad[k])
    );
  end

  assign sad_out0  = sad[0];
  assign sad_out1  = sad[1];
  assign sad_out2  = sad[2];
  assign sad_out3  = sad[3];
  assign sad_out4  = sad[4];
  assign sad_out5  = sad[5];
  assign sad_out6  = sad[6];
  assign sad_out7  = sad[7];
  assign sad_out8  = sad[8];
  assign sad_out9  = sad[9];
  assign sad_out10 = sad[10];
  assign sad_out11 = sad[11];
  assign sad_out12 = sad[12];
  assign sad_out13 = sad[13];
  assign sad_out14 = sad[14];
  assign sad_out15 = sad[15];

endmodule

// File: tb/tb_sad_array16.sv
// Directed testbench for sad_array16: default 256-pixel instance plus a
// 16384-pixel instance for the no-wrap boundary.
module tb_sad_array16;

  logic         clk;
  logic         rst;
  logic         blk_clr;
  logic         pix_valid;
  logic         pix_ready;
  logic [7:0]   cur_pix;
  logic [127:0] ref_pix;
  logic [7:0]   pix_idx;
  logic         sad_valid;
  logic         sad_ready;
  logic [21:0]  sad_o [16];

  logic         b_clr;
  logic         b_valid;
  logic         b_pix_ready;
  logic [7:0]   b_cur;
  logic [127:0] b_ref;
  logic [13:0]  b_pix_idx;
  logic         b_sad_valid;
  logic         b_sad_ready;
  logic [21:0]  b_o [16];

  int checks;
  int errors;

  sad_array16 u_dut (
    .clk(clk), .rst(rst), .blk_clr(blk_clr), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .cur_pix(cur_pix), .ref_pix(ref_pix), .pix_idx(pix_idx), .sad_valid(sad_valid),
    .sad_ready(sad_ready),
    .sad_out0(sad_o[0]),   .sad_out1(sad_o[1]),   .sad_out2(sad_o[2]),   .sad_out3(sad_o[3]),
    .sad_out4(sad_o[4]),   .sad_out5(sad_o[5]),   .sad_out6(sad_o[6]),   .sad_out7(sad_o[7]),
    .sad_out8(sad_o[8]),   .sad_out9(sad_o[9]),   .sad_out10(sad_o[10]), .sad_out11(sad_o[11]),
    .sad_out12(sad_o[12]), .sad_out13(sad_o[13]), .sad_out14(sad_o[14]), .sad_out15(sad_o[15])
  );

  sad_array16 #(
    .PIX_W(8), .SAD_W(22), .BLK_PIXELS(16384), .CNT_W(14)
  ) u_big (
    .clk(clk), .rst(rst), .blk_clr(b_clr), .pix_valid(b_valid), .pix_ready(b_pix_ready),
    .cur_pix(b_cur), .ref_pix(b_ref), .pix_idx(b_pix_idx), .sad_valid(b_sad_valid),
    .sad_ready(b_sad_ready),
    .sad_out0(b_o[0]),   .sad_out1(b_o[1]),   .sad_out2(b_o[2]),   .sad_out3(b_o[3]),
    .sad_out4(b_o[4]),   .sad_out5(b_o[5]),   .sad_out6(b_o[6]),   .sad_out7(b_o[7]),
    .sad_out8(b_o[8]),   .sad_out9(b_o[9]),   .sad_out10(b_o[10]), .sad_out11(b_o[11]),
    .sad_out12(b_o[12]), .sad_out13(b_o[13]), .sad_out14(b_o[14]), .sad_out15(b_o[15])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference vector with lane k = (a + b*k) mod 256.
  function automatic logic [127:0] ref_lin(input int a, input int b);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'((a + b * k) & 255);
    return r;
  endfunction

  function automatic int absd(input int x, input int y);
    return (x > y) ? x - y : y - x;
  endfunction

  // Present one pixel and hold it until accepted (bounded wait).
  task automatic push(input logic [7:0] c, input logic [127:0] r);
    int budget;
    cur_pix   = c;
    ref_pix   = r;
    pix_valid = 1'b1;
    budget    = 0;
    #1;
    while (!pix_ready && budget < 50) begin
      @(posedge clk); #2;
      budget++;
    end
    if (!pix_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: pix_ready=%0b required 1 at pix_idx=%0d", pix_ready, pix_idx);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic stream_block(input int c, input int a, input int b);
    for (int i = 0; i < 256; i++) push(8'(c), ref_lin(a, b));
  endtask

  task automatic test_reset();
    checks++;
    if (pix_idx !== 8'd0) begin errors++; $display("FAIL reset_pix_idx: got %0d want 0", pix_idx); end
    checks++;
    if (sad_valid !== 1'b0) begin errors++; $display("FAIL reset_sad_valid: got %0b want 0", sad_valid); end
    checks++;
    if (pix_ready !== 1'b1) begin errors++; $display("FAIL reset_pix_ready: got %0b want 1", pix_ready); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (sad_o[k] !== 22'd0) begin errors++; $display("FAIL reset_sad_out%0d: got %0d want 0", k, sad_o[k]); end
    end
  endtask

  task automatic test_linear();
    logic [21:0] exp_v;
    sad_ready = 1'b1;
    stream_block(10, 0, 1);
    checks++;
    if (sad_valid !== 1'b1) begin errors++; $display("FAIL lin_valid: got %0b want 1", sad_valid); end
    checks++;
    if (pix_idx !== 8'd0) begin errors++; $display("FAIL lin_pix_idx: got %0d want 0", pix_idx); end
    for (int k = 0; k < 16; k++) begin
      exp_v = 22'(256 * absd(10, k));
      checks++;
      if (sad_o[k] !== exp_v) begin errors++; $display("FAIL lin_sad_out%0d: got %0d want %0d", k, sad_o[k], exp_v); end
    end
    @(posedge clk); #1;
    checks++;
    if (sad_valid !== 1'b0) begin errors++; $display("FAIL lin_valid_drop: got %0b want 0", sad_valid); end
    checks++;
    if (sad_o[0] !== 22'd2560) begin errors++; $display("FAIL lin_hold_out0: got %0d want 2560", sad_o[0]); end
  endtask

  task automatic test_max();
    sad_ready = 1'b1;
    stream_block(255, 0, 0);
    checks++;
    if (sad_valid !== 1'b1) begin errors++; $display("FAIL max_valid: got %0b want 1", sad_valid); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (sad_o[k] !== 22'd65280) begin errors++; $display("FAIL max_sad_out%0d: got %0d want 65280", k, sad_o[k]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_max_big();
    b_sad_ready = 1'b1;
    b_cur       = 8'd255;
    b_ref       = '0;
    b_valid     = 1'b1;
    repeat (16383) @(posedge clk);
    #1;
    checks++;
    if (b_pix_idx !== 14'd16383) begin errors++; $display("FAIL big_pix_idx: got %0d want 16383", b_pix_idx); end
    checks++;
    if (b_pix_ready !== 1'b1) begin errors++; $display("FAIL big_pix_ready: got %0b want 1", b_pix_ready); end
    @(posedge clk); #1;
    b_valid = 1'b0;
    checks++;
    if (b_sad_valid !== 1'b1) begin errors++; $display("FAIL big_valid: got %0b want 1", b_sad_valid); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (b_o[k] !== 22'd4177920) begin errors++; $display("FAIL big_sad_out%0d: got %0d want 4177920", k, b_o[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] e1 [16];
    logic [21:0] e2 [16];
    for (int k = 0; k < 16; k++) begin
      e1[k] = 22'(256 * absd(20, k));
      e2[k] = 22'(512 * k);
    end
    sad_ready = 1'b0;
    stream_block(20, 0, 1);
    checks++;
    if (sad_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %0b want 1", sad_valid); end
    for (int i = 0; i < 255; i++) push(8'd0, ref_lin(0, 2));
    checks++;
    if (pix_idx !== 8'd255) begin errors++; $display("FAIL b2b_idx255: got %0d want 255", pix_idx); end
    cur_pix   = 8'd0;
    ref_pix   = ref_lin(0, 2);
    pix_valid = 1'b1;
    #1;
    checks++;
    if (pix_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall: pix_ready=%0b want 0", pix_ready); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pix_idx !== 8'd255) begin errors++; $display("FAIL b2b_idx_hold: got %0d want 255", pix_idx); end
    checks++;
    if (pix_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_hold: pix_ready=%0b want 0", pix_ready); end
    checks++;
    if (sad_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_hold: got %0b want 1", sad_valid); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (sad_o[k] !== e1[k]) begin errors++; $display("FAIL b2b_stable_out%0d: got %0d want %0d", k, sad_o[k], e1[k]); end
    end
    sad_ready = 1'b1;
    #1;
    checks++;
    if (pix_ready !== 1'b1) begin errors++; $display("FAIL b2b_release: pix_ready=%0b want 1", pix_ready); end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    checks++;
    if (sad_valid !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble: sad_valid=%0b want 1", sad_valid); end
    checks++;
    if (pix_idx !== 8'd0) begin errors++; $display("FAIL b2b_idx_wrap: got %0d want 0", pix_idx); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (sad_o[k] !== e2[k]) begin errors++; $display("FAIL b2b_block2_out%0d: got %0d want %0d", k, sad_o[k], e2[k]); end
    end
    @(posedge clk); #1;
    checks++;
    if (sad_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %0b want 0", sad_valid); end
  endtask

  task automatic test_gaps();
    int exp_i [16];
    int g;
    for (int k = 0; k < 16; k++) exp_i[k] = 0;
    sad_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      g = 0;
      while (g < 5 && $urandom_range(0, 9) < 3) begin
        @(posedge clk); #1;
        checks++;
        if (pix_idx !== 8'(i)) begin errors++; $display("FAIL gap_idx_hold: got %0d want %0d", pix_idx, i); end
        g++;
      end
      for (int k = 0; k < 16; k++) exp_i[k] += absd((i * 7) & 255, (i * 13 + k * 29) & 255);
      push(8'((i * 7) & 255), ref_lin(i * 13, 29));
      if (i < 255) begin
        checks++;
        if (pix_idx !== 8'(i + 1)) begin errors++; $display("FAIL gap_idx_step: got %0d want %0d", pix_idx, i + 1); end
      end
    end
    checks++;
    if (sad_valid !== 1'b1) begin errors++; $display("FAIL gap_valid: got %0b want 1", sad_valid); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (sad_o[k] !== 22'(exp_i[k])) begin errors++; $display("FAIL gap_sad_out%0d: got %0d want %0d", k, sad_o[k], exp_i[k]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_blk_clr();
    logic [21:0] exp_v;
    sad_ready = 1'b1;
    for (int i = 0; i < 100; i++) push(8'd200, ref_lin(0, 0));
    checks++;
    if (pix_idx !== 8'd100) begin errors++; $display("FAIL clr_idx100: got %0d want 100", pix_idx); end
    blk_clr   = 1'b1;
    pix_valid = 1'b1;
    cur_pix   = 8'd50;
    ref_pix   = ref_lin(0, 0);
    @(posedge clk); #1;
    blk_clr   = 1'b0;
    pix_valid = 1'b0;
    checks++;
    if (pix_idx !== 8'd0) begin errors++; $display("FAIL clr_idx_zero: got %0d want 0", pix_idx); end
    stream_block(5, 0, 1);
    checks++;
    if (sad_valid !== 1'b1) begin errors++; $display("FAIL clr_clean_valid: got %0b want 1", sad_valid); end
    for (int k = 0; k < 16; k++) begin
      exp_v = 22'(256 * absd(5, k));
      checks++;
      if (sad_o[k] !== exp_v) begin errors++; $display("FAIL clr_clean_out%0d: got %0d want %0d", k, sad_o[k], exp_v); end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 255; i++) push(8'd99, ref_lin(0, 0));
    blk_clr   = 1'b1;
    pix_valid = 1'b1;
    cur_pix   = 8'd99;
    @(posedge clk); #1;
    blk_clr   = 1'b0;
    pix_valid = 1'b0;
    checks++;
    if (sad_valid !== 1'b0) begin errors++; $display("FAIL clr_last_valid: got %0b want 0", sad_valid); end
    checks++;
    if (pix_idx !== 8'd0) begin errors++; $display("FAIL clr_last_idx: got %0d want 0", pix_idx); end
    checks++;
    if (sad_o[0] !== 22'd1280) begin errors++; $display("FAIL clr_last_out0: got %0d want 1280", sad_o[0]); end
    @(posedge clk); #1;
    checks++;
    if (sad_valid !== 1'b0) begin errors++; $display("FAIL clr_last_valid_late: got %0b want 0", sad_valid); end
  endtask

  task automatic test_mid_reset();
    sad_ready = 1'b0;
    stream_block(3, 0, 0);
    for (int i = 0; i < 50; i++) push(8'd7, ref_lin(1, 1));
    checks++;
    if (pix_idx !== 8'd50 || sad_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup: pix_idx=%0d sad_valid=%0b want 50/1", pix_idx, sad_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (sad_valid !== 1'b0) begin errors++; $display("FAIL rst_sad_valid: got %0b want 0", sad_valid); end
    checks++;
    if (pix_idx !== 8'd0) begin errors++; $display("FAIL rst_pix_idx: got %0d want 0", pix_idx); end
    checks++;
    if (pix_ready !== 1'b1) begin errors++; $display("FAIL rst_pix_ready: got %0b want 1", pix_ready); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (sad_o[k] !== 22'd0) begin errors++; $display("FAIL rst_sad_out%0d: got %0d want 0", k, sad_o[k]); end
    end
    sad_ready = 1'b1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    blk_clr     = 1'b0;
    pix_valid   = 1'b0;
    cur_pix     = '0;
    ref_pix     = '0;
    sad_ready   = 1'b0;
    b_clr       = 1'b0;
    b_valid     = 1'b0;
    b_cur       = '0;
    b_ref       = '0;
    b_sad_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    test_reset();
    test_linear();
    test_max();
    test_max_big();
    test_back_to_back();
    test_gaps();
    test_blk_clr();
    test_mid_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
